if_bus_fetch: RTL and testbench
===============================

Name: if_bus_fetch

Overview:
- Instruction-fetch bus master that sits directly upstream of the IF pipeline register.
- Takes the current fetch word address (if_pc) and runs one read transaction per instruction on the shared system bus. The bus protocol is request/grant arbitration, then address strobe, then a ready-terminated data phase.
- Returns the fetched word as insn and asserts busy, which the pipeline controller ORs into the IF stall, until the word is valid.

Parameters:
- ADDR_W, 30, word-address width (bus_addr, pc).
- DATA_W, 32, instruction/data word width.
- NOP_WORD, 32'h0000_0000, value driven on insn after reset/flush (matches ISA NOP encoding).
- TIMEOUT_CYC, 255, max cycles waiting for bus_rdy (used only with optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc  in  ADDR_W  word address to fetch (IF-stage PC).
- fetch_en  in  1  request a fetch of pc this cycle.
- flush  in  1  pipeline flush; abandon current fetch.
- insn  out  DATA_W  last fetched instruction, registered.
- insn_vld  out  1  one-cycle pulse: insn updated this cycle.
- busy  out  1  fetch in progress; IF stage must stall.
- fetch_err  out  1  sticky-for-one-cycle timeout error (optional feature; tied 0 otherwise).
- bus_req  out  1  bus request to arbiter.
- bus_grant  in  1  arbiter grant.
- bus_as  out  1  address strobe, one cycle per transaction.
- bus_addr  out  ADDR_W  registered transaction address.
- bus_rw  out  1  always 1 (read).
- bus_rdy  in  1  slave data ready, valid in the cycle it is high.
- bus_rd_data  in  DATA_W  read data, sampled when bus_rdy=1.

Behaviour:
- Reset values: insn=NOP_WORD, insn_vld=0, busy=0, bus_req=0, bus_as=0, bus_addr=0, fetch_err=0, state=IDLE.
- Rst has priority over all inputs. A reset in any state, including mid-transaction, returns to IDLE and drops bus_req/bus_as next edge.
- FSM states and transitions:
  - IDLE: fetch_en=1 and flush=0 → latch pc into bus_addr, set bus_req=1, go REQ. Otherwise stay; bus_req=0.
  - REQ: bus_req held 1.
    - flush=1 → bus_req=0, go IDLE; no bus cycle issued.
    - else bus_grant=1 → bus_as=1 for exactly one cycle, go ACCESS.
  - ACCESS: bus_req held 1, bus_as=0.
    - bus_rdy=1 and flush=0 → insn<=bus_rd_data, insn_vld=1 next cycle, go IDLE, bus_req=0.
    - bus_rdy=1 and flush=1 → data discarded, insn<=NOP_WORD, go IDLE.
    - bus_rdy=0 and flush=1 → go DISCARD.
  - DISCARD: the bus transaction is not abortable. Wait for bus_rdy, drop the data, then go IDLE; insn<=NOP_WORD.
- busy (combinational):
  - 1 in REQ, ACCESS and DISCARD.
  - 1 in IDLE when fetch_en=1 and flush=0.
  - 0 in the cycle ACCESS sees bus_rdy=1, so the IF register advances on the same edge insn is written.
- Minimum latency: fetch_en at cycle 0, REQ at 1, bus_as at 1 if grant already high, rdy at 2 → insn valid at 3.
- Simultaneous flush and fetch_en in IDLE: flush wins, no request.
- pc changes while busy are ignored; bus_addr holds the latched value until the transaction ends.
- bus_grant dropping during ACCESS has no effect; the transaction completes on bus_rdy.
- insn holds its value between fetches. insn_vld is 0 except the single completion cycle.

Optional Feature:
- Macro: IF_FETCH_TIMEOUT_EN.
- With the macro defined:
  - An 8+-bit counter clears on bus_as and increments each ACCESS/DISCARD cycle without bus_rdy.
  - When the counter reaches TIMEOUT_CYC: go IDLE, bus_req=0, insn<=NOP_WORD, fetch_err=1 for one cycle, busy=0 that cycle.
- Without the macro: no counter is generated, fetch_err is tied 0, and the FSM waits indefinitely for bus_rdy.

Test Plan:
- Reset mid-ACCESS (rst=1 at cycle after bus_as) → next edge bus_req=0, busy=0, insn=NOP_WORD; late bus_rdy ignored.
- pc=0x100, fetch_en=1, grant held high, rdy 1 cycle after bus_as, data 0xDEADBEEF:
  - bus_addr=0x100 and bus_as pulses once.
  - insn=0xDEADBEEF with insn_vld pulse at cycle 3.
  - busy high for cycles 0-1, low at cycle 2.
- Grant delayed 4 cycles, rdy delayed 3 wait states → bus_as only after grant; busy continuous until rdy cycle; insn correct.
- Flush in REQ before grant → bus_req drops next cycle, no bus_as ever, insn unchanged.
- Flush in ACCESS with rdy 2 cycles later (data 0x12345678) → DISCARD; insn=NOP_WORD, no insn_vld, busy high until rdy.
- IF_FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, bus_rdy never asserted → fetch_err pulse 4 cycles after bus_as, insn=NOP_WORD, FSM IDLE.

Source files
------------

// File: rtl/if_bus_fetch.sv
// ---------------------------------------------------------------------------
// if_bus_fetch
//
// Instruction-fetch bus master sitting directly upstream of the IF pipeline
// register. It runs one read transaction per instruction on the shared system
// bus. Each transaction is request/grant arbitration, then a one-cycle address
// strobe, then a data phase that ends on bus_rdy. The fetched word is returned
// on insn. busy is held high until the word is valid, and the pipeline
// controller ORs it into the IF stall.
//
// Optional feature: when the IF_FETCH_TIMEOUT_EN macro is defined, a wait
// counter abandons a data phase that has gone TIMEOUT_CYC cycles without
// bus_rdy. In that case fetch_err pulses and insn is loaded with NOP_WORD.
// Without the macro, fetch_err is tied low and the FSM waits indefinitely.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc              word address to fetch (sampled only when a fetch starts)
//   fetch_en        request a fetch of pc this cycle
//   flush           abandon the current fetch
//   insn            last fetched instruction (registered)
//   insn_vld        one-cycle pulse: insn updated with fetched data
//   busy            fetch in progress, IF stage must stall (combinational)
//   fetch_err       one-cycle timeout indication (optional feature)
//   bus_req         request to the bus arbiter
//   bus_grant       arbiter grant
//   bus_as          address strobe, one cycle per transaction
//   bus_addr        registered transaction address
//   bus_rw          read/write select, constant read (1)
//   bus_rdy         slave data ready
//   bus_rd_data     read data, valid while bus_rdy=1
// ---------------------------------------------------------------------------
module if_bus_fetch #(
  parameter int                 ADDR_W      = 30,
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD    = 32'h0000_0000,
  parameter int                 TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [DATA_W-1:0] insn,
  output logic              insn_vld,
  output logic              busy,
  output logic              fetch_err,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_as,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACCESS  = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                load_addr;
  logic [DATA_W-1:0]   insn_nxt;
  logic                insn_vld_nxt;
  logic                timeout;

  // A timeout threshold below 2 would fire before the data phase could end.
  if (TIMEOUT_CYC < 2) begin : g_timeout_range
    $error("if_bus_fetch: TIMEOUT_CYC must be at least 2");
  end

  assign bus_rw = 1'b1;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;

  // The timeout fires in the wait cycle that would bring the count to
  // TIMEOUT_CYC. That lets the FSM leave on the same edge the count gets there.
  assign timeout = (wait_cnt == CNT_LAST);

  // Wait-state counter: cleared by the address strobe, advanced on every
  // data-phase cycle that has no bus_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (bus_as) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (((state == S_ACCESS) || (state == S_DISCARD)) && !bus_rdy) begin
      wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt <= wait_cnt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and combinational outputs. bus_as and busy are decoded from the
  // current state so the strobe can go out in the same cycle the grant arrives.
  always_comb begin
    state_nxt    = state;
    load_addr    = 1'b0;
    insn_nxt     = insn;
    insn_vld_nxt = 1'b0;
    busy         = 1'b0;
    bus_as       = 1'b0;
    fetch_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          busy      = 1'b1;
          load_addr = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (bus_grant) begin
          bus_as    = 1'b1;
          state_nxt = S_ACCESS;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_ACCESS: begin
        if (bus_rdy) begin
          // busy drops here so the IF register advances on the edge that writes insn.
          busy         = 1'b0;
          state_nxt    = S_IDLE;
          insn_nxt     = flush ? NOP_WORD : bus_rd_data;
          insn_vld_nxt = !flush;
        end else if (timeout) begin
          fetch_err = 1'b1;
          state_nxt = S_IDLE;
          insn_nxt  = NOP_WORD;
        end else if (flush) begin
          // The bus cycle cannot be aborted, so wait it out in DISCARD.
          busy      = 1'b1;
          state_nxt = S_DISCARD;
        end else begin
          busy      = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_DISCARD: begin
        if (bus_rdy) begin
          busy      = 1'b1;
          state_nxt = S_IDLE;
          insn_nxt  = NOP_WORD;
        end else if (timeout) begin
          fetch_err = 1'b1;
          state_nxt = S_IDLE;
          insn_nxt  = NOP_WORD;
        end else begin
          busy      = 1'b1;
          state_nxt = S_DISCARD;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs. bus_req follows the next state, so it is high
  // for the whole life of a transaction and drops on the edge that returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      insn     <= NOP_WORD;
      insn_vld <= 1'b0;
      bus_req  <= 1'b0;
      bus_addr <= {ADDR_W{1'b0}};
    end else begin
      state    <= state_nxt;
      insn     <= insn_nxt;
      insn_vld <= insn_vld_nxt;
      bus_req  <= (state_nxt != S_IDLE);
      if (load_addr) begin
        bus_addr <= pc;
      end else begin
        bus_addr <= bus_addr;
      end
    end
  end

endmodule

// File: tb/tb_if_bus_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for if_bus_fetch. Each transaction is described by its grant delay,
// its wait states and an optional flush point. The expected per-cycle
// behaviour is worked out from that transaction timeline with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_if_bus_fetch;
  localparam int          ADDR_W = 30;
  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_FETCH_TIMEOUT_EN
  localparam int          TO_CYC = 4;
`else
  localparam int          TO_CYC = 255;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] pc = '0;
  logic              fetch_en = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] insn;
  logic              insn_vld;
  logic              busy;
  logic              fetch_err;
  logic              bus_req;
  logic              bus_grant = 1'b0;
  logic              bus_as;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic              bus_rdy = 1'b0;
  logic [DATA_W-1:0] bus_rd_data = '0;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_insn;

  if_bus_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .insn(insn), .insn_vld(insn_vld), .busy(busy), .fetch_err(fetch_err),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_rdy(bus_rdy),
    .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    fetch_en    = 1'b0;
    flush       = 1'b0;
    bus_grant   = 1'b0;
    bus_rdy     = 1'b0;
    pc          = ADDR_W'($urandom);
    bus_rd_data = $urandom;
  endtask

  // mode 0: plain fetch. mode 1: flush in REQ at cycle f. mode 2: flush in the
  // data phase at cycle f. g = grant delay, w = wait states.
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input int g, input int w,
                         input int mode, input int f, input logic [DATA_W-1:0] data);
    int as_c;
    int rdy_c;
    int last;
    as_c  = 1 + g;
    rdy_c = 2 + g + w;
    last  = (mode == 1) ? f + 1 : rdy_c + 1;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      pc          = (c == 0) ? addr : ADDR_W'($urandom);
      fetch_en    = (c == 0) ? 1'b1 : ((c < last) ? 1'($urandom_range(0, 1)) : 1'b0);
      flush       = (mode != 0) && (c == f);
      if (mode == 1) begin
        bus_grant = (c < f) ? 1'b0 : ((c == f) ? 1'($urandom_range(0, 1)) : 1'b1);
      end else begin
        bus_grant = (c < as_c) ? 1'b0 : ((c == as_c) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      bus_rdy     = (mode != 1) && (c == rdy_c);
      bus_rd_data = bus_rdy ? data : $urandom;
      #1;
      if (c == last) begin
        if (mode == 0) exp_insn = data;
        if (mode == 2) exp_insn = NOP;
      end
      check_eq("insn", insn, exp_insn);
      check_eq("insn_vld", insn_vld, (mode == 0) && (c == last));
      check_eq("bus_as", bus_as, (mode != 1) && (c == as_c));
      check_eq("fetch_err", fetch_err, 1'b0);
      if (c >= 1) check_eq("bus_addr", bus_addr, addr);
      if (mode == 1) begin
        check_eq("busy", busy, c <= f);
        check_eq("bus_req", bus_req, (c >= 1) && (c <= f));
      end else begin
        if (!((mode == 2) && (f < rdy_c) && (c == rdy_c)))
          check_eq("busy", busy, c < rdy_c);
        check_eq("bus_req", bus_req, (c >= 1) && (c <= rdy_c));
      end
    end
    drive_idle();
  endtask

  initial begin
    int g;
    int w;
    int mode;
    int f;
    exp_insn = NOP;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_insn", insn, NOP);
    check_eq("rst_vld", insn_vld, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req", bus_req, 1'b0);
    check_eq("rst_as", bus_as, 1'b0);
    check_eq("rst_addr", bus_addr, '0);
    check_eq("rst_err", fetch_err, 1'b0);
    check_eq("bus_rw", bus_rw, 1'b1);
    rst = 1'b0;

    // Directed cases: minimum latency, slow grant and slave, flushes.
    run_txn(ADDR_W'(32'h100), 0, 0, 0, 0, 32'hDEAD_BEEF);
    run_txn(ADDR_W'($urandom), 4, 3, 0, 0, $urandom);
    run_txn(ADDR_W'($urandom), 3, 1, 1, 2, $urandom);
    run_txn(ADDR_W'($urandom), 0, 2, 2, 2, 32'h1234_5678);
    run_txn(ADDR_W'($urandom), 1, 0, 0, 0, $urandom);
    run_txn(ADDR_W'($urandom), 1, 2, 2, 5, $urandom);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      g    = $urandom_range(0, 4);
      w    = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      f    = (mode == 1) ? $urandom_range(1, 1 + g) : $urandom_range(2 + g, 2 + g + w);
      run_txn(ADDR_W'($urandom), g, w, mode, f, $urandom);
    end

    // Flush together with fetch_en in IDLE: flush wins.
    @(negedge clk);
    fetch_en = 1'b1; flush = 1'b1; bus_grant = 1'b1; #1;
    check_eq("ff_busy", busy, 1'b0);
    @(negedge clk);
    fetch_en = 1'b0; flush = 1'b0; #1;
    check_eq("ff_req", bus_req, 1'b0);
    check_eq("ff_as", bus_as, 1'b0);
    drive_idle();

    // Make sure insn holds fetched data before the reset test.
    run_txn(ADDR_W'($urandom), 0, 0, 0, 0, 32'hCAFE_F00D);

    // Reset in the data phase, followed by a late bus_rdy.
    @(negedge clk); fetch_en = 1'b1; bus_grant = 1'b1;
    @(negedge clk); fetch_en = 1'b0; #1;
    check_eq("rm_as", bus_as, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hBAD0_BAD0; #1;
    exp_insn = NOP;
    check_eq("rm_req", bus_req, 1'b0);
    check_eq("rm_busy", busy, 1'b0);
    check_eq("rm_insn", insn, NOP);
    check_eq("rm_as", bus_as, 1'b0);
    @(negedge clk); bus_rdy = 1'b0; #1;
    check_eq("rm_late_insn", insn, NOP);
    check_eq("rm_late_vld", insn_vld, 1'b0);
    check_eq("rm_late_req", bus_req, 1'b0);
    drive_idle();

`ifdef IF_FETCH_TIMEOUT_EN
    // Slave never answers. The strobe is at cycle 1, so the error is at cycle 5.
    run_txn(ADDR_W'($urandom), 0, 0, 0, 0, 32'h5555_AAAA);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      fetch_en  = (c == 0);
      bus_grant = 1'b1;
      bus_rdy   = 1'b0;
      #1;
      check_eq("to_err", fetch_err, c == 5);
      if (c >= 2 && c <= 5) check_eq("to_busy", busy, c < 5);
      if (c >= 6) begin
        check_eq("to_insn", insn, NOP);
        check_eq("to_req", bus_req, 1'b0);
        check_eq("to_vld", insn_vld, 1'b0);
      end
    end
    exp_insn = NOP;
    drive_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
